// File: rtl/window5_gen.sv
`default_nettype none
// ============================================================================
// Module      : window5_gen
// Description : Sliding 5-sample window generator feeding the peak comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module window5_gen #(
    parameter int DATA_WIDTH = 46,
    parameter int PAD_EDGES  = 1,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_sample_value,
    input  logic                    in_sample_valid,
    input  logic                    in_sample_last,
    output logic                    in_sample_ready,
    output logic [DATA_WIDTH*5-1:0] out_window_value,
    output logic                    out_window_valid,
    output logic [IDX_WIDTH-1:0]    out_window_center_idx,
    output logic                    out_window_last
);

    localparam int               c_WIN_W  = DATA_WIDTH * 5;
    localparam logic             c_PAD    = (PAD_EDGES != 0);
    localparam logic [1:0]       c_RUN    = 2'd0;
    localparam logic [1:0]       c_FLUSH1 = 2'd1;
    localparam logic [1:0]       c_FLUSH2 = 2'd2;
    localparam logic [2:0]       c_J_MAX  = 3'd4;
    localparam logic [2:0]       c_EMIT_J = (PAD_EDGES != 0) ? 3'd2 : 3'd4;
    // Without padding the first window is centred on the third sample.
    localparam logic [IDX_WIDTH-1:0] c_IDX_START =
        (PAD_EDGES != 0) ? {IDX_WIDTH{1'b0}} : IDX_WIDTH'(2);

    logic [1:0]            r_state;
    logic                  r_ready;
    logic [c_WIN_W-1:0]    r_win;
    logic [2:0]            r_j;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [c_WIN_W-1:0]    r_out_value;
    logic                  r_out_valid;
    logic [IDX_WIDTH-1:0]  r_out_idx;
    logic                  r_out_last;

    logic                  w_accept;
    logic                  w_shift;
    logic [DATA_WIDTH-1:0] w_incoming;
    logic [c_WIN_W-1:0]    w_shifted;
    logic                  w_emit;
    logic                  w_frame_end;
    logic [1:0]            w_state_nxt;

    always_comb begin
        w_accept    = in_sample_valid && r_ready && (r_state == c_RUN);
        w_shift     = w_accept || (r_state != c_RUN);
        w_incoming  = w_accept ? in_sample_value : {DATA_WIDTH{1'b0}};
        w_shifted   = {w_incoming, r_win[c_WIN_W-1:DATA_WIDTH]};
        w_emit      = w_shift && (r_j >= c_EMIT_J);
        // Padded frames end after the second flush; unpadded ones on last.
        w_frame_end = (r_state == c_FLUSH2) ||
                      (w_accept && in_sample_last && !c_PAD);
        w_state_nxt = r_state;
        case (r_state)
            c_RUN: begin
                if (w_accept && in_sample_last && c_PAD) begin
                    w_state_nxt = c_FLUSH1;
                end
            end
            c_FLUSH1: w_state_nxt = c_FLUSH2;
            c_FLUSH2: w_state_nxt = c_RUN;
            default:  w_state_nxt = c_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_RUN;
            r_ready     <= 1'b1;
            r_win       <= '0;
            r_j         <= 3'd0;
            r_idx       <= c_IDX_START;
            r_out_value <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == c_RUN);

            if (w_frame_end) begin
                r_win <= '0;
                r_j   <= 3'd0;
                r_idx <= c_IDX_START;
            end else if (w_shift) begin
                r_win <= w_shifted;
                if (r_j != c_J_MAX) begin
                    r_j <= r_j + 3'd1;
                end
                if (w_emit) begin
                    r_idx <= r_idx + IDX_WIDTH'(1);
                end
            end

            r_out_valid <= w_emit;
            r_out_value <= w_emit ? w_shifted : '0;
            r_out_idx   <= w_emit ? r_idx : '0;
            r_out_last  <= w_emit && w_frame_end;
        end
    end

    assign in_sample_ready       = r_ready;
    assign out_window_value      = r_out_value;
    assign out_window_valid      = r_out_valid;
    assign out_window_center_idx = r_out_idx;
    assign out_window_last       = r_out_last;

endmodule
`default_nettype wire
